// File: rtl/cpuc_max_ctrl.sv
// Streaming maximum finder: scans len elements and reports the largest value
// together with the index of its first occurrence, using a valid/ready handshake.

package cpuc_package;
  parameter int DATA_WIDTH = 32;
  parameter bit SIGNED_CMP = 1'b0;
endpackage

module cpuc_cmp
  import cpuc_package::*;
#(
  parameter int W      = DATA_WIDTH,
  parameter bit SIGNED = SIGNED_CMP
) (
  input  logic [W-1:0] data_in1,
  input  logic [W-1:0] data_in2,
  output logic [W-1:0] data_out,
  output logic         gt
);

  // gt is strict so that ties keep data_in2, the earlier running maximum
  always_comb begin
    if (SIGNED) gt = $signed(data_in1) > $signed(data_in2);
    else        gt = data_in1 > data_in2;
    data_out = gt ? data_in1 : data_in2;
  end

endmodule

module cpuc_max_ctrl
  import cpuc_package::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_max,
  output logic [CNT_WIDTH-1:0]  out_idx,
  input  logic                  out_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                state, next_state;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] cmp_max;
  logic                  cmp_gt;
  logic                  transfer;
  logic                  last;

  cpuc_cmp #(.W(DATA_WIDTH), .SIGNED(SIGNED_CMP)) u_cmp (
    .data_in1 (in_data),
    .data_in2 (out_max),
    .data_out (cmp_max),
    .gt       (cmp_gt)
  );

  assign transfer = in_valid && in_ready;
  assign last     = transfer && (cnt == len_q - CNT_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && len != '0) next_state = ACCUM;
      ACCUM:   if (last) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
    busy      = (state == ACCUM) || (state == DONE);
  end

  // Counter only reaches len, which always fits in CNT_WIDTH, so it never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      cnt     <= '0;
      out_max <= '0;
      out_idx <= '0;
    end else begin
      if (state == IDLE && start && len != '0) begin
        len_q <= len;
        cnt   <= '0;
      end
      if (transfer) begin
        cnt <= cnt + CNT_WIDTH'(1);
        if (cnt == '0) begin
          out_max <= in_data;
          out_idx <= '0;
        end else begin
          out_max <= cmp_max;
          if (cmp_gt) out_idx <= cnt;
        end
      end
    end
  end

endmodule

// File: doc/cpuc_max_ctrl.md
CPUC_MAX_CTRL -- requirements
Module: cpuc_max_ctrl

Interface
REQ-001 The block SHALL take DATA_WIDTH and SIGNED_CMP from cpuc_package.
REQ-002 Parameter: CNT_WIDTH, default 8, width of the length and index fields.
REQ-003 Port: clk  input  1  the single clock; every register SHALL be clocked on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  begin a scan; sampled only in IDLE.
REQ-006 Port: len  input  CNT_WIDTH  number of elements to scan; sampled with start.
REQ-007 Port: in_valid  input  1  in_data is valid.
REQ-008 Port: in_data  input  DATA_WIDTH  element value.
REQ-009 Port: in_ready  output  1  block accepts an element this cycle.
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_max  output  DATA_WIDTH  maximum value of the scan.
REQ-012 Port: out_idx  output  CNT_WIDTH  position of the first occurrence of the maximum, counted from 0.
REQ-013 Port: out_ready  input  1  consumer accepts the result.
REQ-014 Port: busy  output  1  a scan is in progress (ACCUM or DONE).

Function
REQ-015 The block SHALL implement an FSM with states IDLE, ACCUM and DONE.
REQ-016 In IDLE with start=1 and len!=0, the block SHALL latch len, clear the element counter and go to ACCUM on the next cycle.
REQ-017 In IDLE with start=1 and len=0, the block SHALL ignore start and stay in IDLE.
REQ-018 start SHALL be ignored in ACCUM and DONE.
REQ-019 in_ready SHALL equal 1 only in ACCUM, and SHALL be driven from state only, with no combinational path from in_valid.
REQ-020 A transfer SHALL occur when in_valid=1 and in_ready=1; with in_valid=1 held, the block SHALL accept one element per cycle.
REQ-021 On the first transfer (counter=0), the block SHALL load out_max with in_data and out_idx with 0, without comparing.
REQ-022 On each later transfer, the block SHALL take the new out_max from an instance of cpuc_cmp with data_in1=in_data and data_in2=out_max.
REQ-023 On each later transfer, the block SHALL load out_idx with the counter only if in_data is strictly greater than out_max, using the signedness set by SIGNED_CMP; on a tie the earlier index SHALL be kept.
REQ-024 The counter SHALL increment by 1 on each transfer.
REQ-025 A transfer with counter = len-1 SHALL move the FSM to DONE on the next cycle, so out_valid rises 1 cycle after the last accepted element.
REQ-026 len = 2^CNT_WIDTH-1 SHALL be supported with no counter wrap.
REQ-027 In DONE, out_valid SHALL be 1, and out_max and out_idx SHALL stay stable until the handshake.
REQ-028 out_valid=1 with out_ready=1 SHALL return the FSM to IDLE on the next cycle.
REQ-029 out_valid SHALL stay asserted while out_ready=0, with no timeout.
REQ-030 out_max and out_idx SHALL hold their last values in IDLE until the first transfer of the next scan.
REQ-031 Cycles with in_valid=0 in ACCUM SHALL leave the counter, out_max and out_idx unchanged.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, counter=0, out_max=0, out_idx=0, out_valid=0, in_ready=0 and busy=0.
REQ-033 A reset during ACCUM or DONE SHALL abort the scan and discard any partial result.
REQ-034 After rst is released, the first start SHALL be accepted on the first rising clk edge.

Verification
REQ-035 Unsigned scan (SIGNED_CMP=0, DATA_WIDTH=32): len=4, back-to-back data 5, 9, 3, 9 -> out_max=9, out_idx=1, out_valid high 1 cycle after the 4th transfer.
REQ-036 Signed scan (SIGNED_CMP=1): data 0xFFFFFFFF, 0x00000002, 0x80000000 -> out_max=2, out_idx=1; the same data with SIGNED_CMP=0 -> out_max=0xFFFFFFFF, out_idx=0.
REQ-037 Single element plus bubbles: len=1, in_valid low for 3 cycles, then data 7 -> out_max=7, out_idx=0, counter unchanged during the bubbles.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse start -> out_valid, out_max and out_idx stable, start ignored, IDLE one cycle after out_ready=1.
REQ-039 len=0 and mid-scan reset: start with len=0 -> stays in IDLE with busy=0; rst asserted after 2 of 4 elements -> all outputs 0 immediately; a new scan of 1 then 2 -> out_max=2, out_idx=1.
